// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART: FSM state encodings,
// divisor width and FIFO pointer sizing.
package uart_pkg;

    localparam int CLKS_PER_BIT_W = 13;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_RECOVER
    } rx_state_t;

    // One extra MSB distinguishes full from empty when the index bits match.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with valid/ready on both sides.
// Read data reads as zero while the FIFO is empty.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_valid,
    output logic             wr_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_wr;
    logic             do_rd;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    assign wr_ready = !full;
    assign rd_valid = !empty;
    assign do_wr    = wr_valid && !full;
    assign do_rd    = rd_ready && !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PW'(1);
            if (do_rd) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/uart_buffered.sv
// Full-duplex UART with TX/RX FIFOs, runtime divisor and sticky error flags.
// Optional parity bit in both directions when UART_PARITY_EN is defined.
module uart_buffered
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CLKS_PER_BIT_W-1:0] clks_per_bit,
    input  logic                      rx_serial,
    output logic                      tx_serial,
    input  logic [DATA_WIDTH-1:0]     tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      tx_busy,
    output logic [DATA_WIDTH-1:0]     rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    input  logic                      parity_odd,
    output logic                      frame_err,
    output logic                      overrun_err,
    output logic                      parity_err,
    input  logic                      err_clear
);

    localparam logic [3:0] LAST_BIT  = 4'(DATA_WIDTH - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    // ---------------- TX ----------------
    tx_state_t                 tx_state;
    logic [CLKS_PER_BIT_W-1:0] tx_div;
    logic [CLKS_PER_BIT_W-1:0] tx_cnt;
    logic [DATA_WIDTH-1:0]     tx_shift;
    logic [3:0]                tx_bit;
    logic                      tx_stop_idx;
    logic [DATA_WIDTH-1:0]     tx_head;
    logic                      tx_head_valid;
    logic                      tx_bit_end;
    logic                      tx_pop;
`ifdef UART_PARITY_EN
    logic                      tx_par;
`endif

    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (tx_data),
        .wr_valid (tx_valid),
        .wr_ready (tx_ready),
        .rd_data  (tx_head),
        .rd_valid (tx_head_valid),
        .rd_ready (tx_pop)
    );

    assign tx_bit_end = (tx_cnt == tx_div - CLKS_PER_BIT_W'(1));
    assign tx_busy    = (tx_state != TX_IDLE) || tx_head_valid;

    // The head is popped from IDLE or at the end of the last stop bit so that
    // queued frames follow each other with no idle gap.
    always_comb begin
        tx_pop = 1'b0;
        case (tx_state)
            TX_IDLE: tx_pop = tx_head_valid;
            TX_STOP: tx_pop = tx_bit_end && (tx_stop_idx == LAST_STOP) && tx_head_valid;
            default: tx_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state    <= TX_IDLE;
            tx_serial   <= 1'b1;
            tx_div      <= '0;
            tx_cnt      <= '0;
            tx_shift    <= '0;
            tx_bit      <= '0;
            tx_stop_idx <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            case (tx_state)
                TX_IDLE: ;
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_cnt    <= '0;
                        tx_bit    <= '0;
                        tx_serial <= tx_shift[0];
                        tx_state  <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + CLKS_PER_BIT_W'(1);
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            tx_serial <= tx_par;
                            tx_state  <= TX_PARITY;
`else
                            tx_serial   <= 1'b1;
                            tx_stop_idx <= 1'b0;
                            tx_state    <= TX_STOP;
`endif
                        end else begin
                            tx_bit    <= tx_bit + 4'd1;
                            tx_shift  <= tx_shift >> 1;
                            tx_serial <= tx_shift[1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + CLKS_PER_BIT_W'(1);
                    end
                end
                TX_PARITY: begin
                    if (tx_bit_end) begin
                        tx_cnt      <= '0;
                        tx_serial   <= 1'b1;
                        tx_stop_idx <= 1'b0;
                        tx_state    <= TX_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + CLKS_PER_BIT_W'(1);
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        tx_cnt <= '0;
                        if (tx_stop_idx == LAST_STOP) tx_state <= TX_IDLE;
                        else tx_stop_idx <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt + CLKS_PER_BIT_W'(1);
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase

            // Frame load overrides the IDLE/STOP assignments above.
            if (tx_pop) begin
                tx_shift  <= tx_head;
                tx_div    <= clks_per_bit;
                tx_cnt    <= '0;
                tx_serial <= 1'b0;
                tx_state  <= TX_START;
`ifdef UART_PARITY_EN
                tx_par    <= (^tx_head) ^ parity_odd;
`endif
            end
        end
    end

    // ---------------- RX ----------------
    rx_state_t                 rx_state;
    logic [1:0]                rx_sync;
    logic                      rx_s;
    logic                      rx_prev;
    logic [CLKS_PER_BIT_W-1:0] rx_div;
    logic [CLKS_PER_BIT_W-1:0] rx_cnt;
    logic [DATA_WIDTH-1:0]     rx_shift;
    logic [3:0]                rx_bit;
    logic                      rx_bit_end;
    logic                      rx_half_end;
    logic                      rx_space;
    logic                      rx_push;

    assign rx_s        = rx_sync[1];
    assign rx_bit_end  = (rx_cnt == rx_div - CLKS_PER_BIT_W'(1));
    assign rx_half_end = (rx_cnt == {1'b0, rx_div[CLKS_PER_BIT_W-1:1]} - CLKS_PER_BIT_W'(1));
    assign rx_push     = (rx_state == RX_STOP) && rx_bit_end && rx_s && rx_space;

    uart_sync_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (rx_shift),
        .wr_valid (rx_push),
        .wr_ready (rx_space),
        .rd_data  (rx_data),
        .rd_valid (rx_valid),
        .rd_ready (rx_ready)
    );

`ifndef UART_PARITY_EN
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
    assign parity_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync     <= 2'b11;
            rx_prev     <= 1'b1;
            rx_state    <= RX_IDLE;
            rx_div      <= '0;
            rx_cnt      <= '0;
            rx_shift    <= '0;
            rx_bit      <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            rx_sync <= {rx_sync[0], rx_serial};
            rx_prev <= rx_s;

            // Clear first; any set below in the same cycle takes precedence.
            if (err_clear) begin
                frame_err   <= 1'b0;
                overrun_err <= 1'b0;
`ifdef UART_PARITY_EN
                parity_err  <= 1'b0;
`endif
            end

            case (rx_state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        rx_div   <= clks_per_bit;
                        rx_cnt   <= '0;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_half_end) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CLKS_PER_BIT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[DATA_WIDTH-1:1]};
                        rx_bit   <= rx_bit + 4'd1;
                        if (rx_bit == LAST_BIT) begin
`ifdef UART_PARITY_EN
                            rx_state <= RX_PARITY;
`else
                            rx_state <= RX_STOP;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CLKS_PER_BIT_W'(1);
                    end
                end
                RX_PARITY: begin
                    if (rx_bit_end) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_STOP;
`ifdef UART_PARITY_EN
                        if (rx_s != ((^rx_shift) ^ parity_odd)) parity_err <= 1'b1;
`endif
                    end else begin
                        rx_cnt <= rx_cnt + CLKS_PER_BIT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (rx_bit_end) begin
                        rx_cnt <= '0;
                        if (rx_s) begin
                            if (!rx_space) overrun_err <= 1'b1;
                            rx_state <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            rx_state  <= RX_RECOVER;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CLKS_PER_BIT_W'(1);
                    end
                end
                RX_RECOVER: begin
                    if (rx_s) rx_state <= RX_IDLE;
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_buffered.sv
// Directed self-checking bench for uart_buffered (RX_DEPTH=4, 8 data bits);
// parity scenarios run when UART_PARITY_EN is defined.
module tb_uart_buffered;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] clks_per_bit;
    logic        rx_serial;
    logic        tx_serial;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        parity_odd;
    logic        frame_err;
    logic        overrun_err;
    logic        parity_err;
    logic        err_clear;

    logic        loop_en;
    logic        rx_drv;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    always #5 clk = ~clk;

    assign rx_serial = loop_en ? tx_serial : rx_drv;

    uart_buffered #(
        .DATA_WIDTH (8),
        .TX_DEPTH   (8),
        .RX_DEPTH   (4),
        .STOP_BITS  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clks_per_bit (clks_per_bit),
        .rx_serial    (rx_serial),
        .tx_serial    (tx_serial),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .parity_odd   (parity_odd),
        .frame_err    (frame_err),
        .overrun_err  (overrun_err),
        .parity_err   (parity_err),
        .err_clear    (err_clear)
    );

    task automatic push(input logic [7:0] d);
        int n;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 tx_valid = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    task automatic clear_errors();
        @(negedge clk);
        err_clear = 1'b1;
        @(posedge clk);
        #1 err_clear = 1'b0;
    endtask

    task automatic hold_bit(input logic b);
        rx_drv = b;
        repeat (clks_per_bit) @(posedge clk);
    endtask

    task automatic drive_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_PARITY_EN
        hold_bit((^d) ^ parity_odd ^ par_flip);
`else
        if (par_flip) rx_drv = 1'b1;
`endif
        hold_bit(stop_v);
        rx_drv = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    // Waits for the start bit on tx_serial; returns 1 if seen within the bound.
    task automatic wait_tx_start(output logic found);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (tx_serial !== 1'b1)   $display("FAIL reset_tx_serial got=%b want=1", tx_serial);
        if (tx_serial !== 1'b1) n_bad++;
        n_cmp++; if (tx_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_tx_ready got=%b want=1", tx_ready); end
        n_cmp++; if (tx_busy !== 1'b0)     begin n_bad++; $display("FAIL reset_tx_busy got=%b want=0", tx_busy); end
        n_cmp++; if (rx_valid !== 1'b0)    begin n_bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
        n_cmp++; if (rx_data !== 8'h00)    begin n_bad++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
        n_cmp++; if ({frame_err, overrun_err, parity_err} !== 3'b000)
            begin n_bad++; $display("FAIL reset_errs got=%b want=000", {frame_err, overrun_err, parity_err}); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_tx_a5();
        logic [10:0] exp_seq;
        logic        found;
        int          bad;
`ifdef UART_PARITY_EN
        exp_seq = 11'b10101001010;
`else
        exp_seq = 11'b01101001010;
`endif
        clks_per_bit = 13'd16;
        push(8'hA5);
        wait_tx_start(found);
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL tx_a5_start got=no_start want=start_bit");
        end else begin
            n_cmp++;
            if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL tx_a5_busy_during got=%b want=1", tx_busy); end
            bad = 0;
            for (int i = 0; i < NB * 16; i++) begin
                if (i > 0) @(negedge clk);
                if (tx_serial !== exp_seq[i / 16] && bad < 4) begin
                    $display("FAIL tx_a5_bit cycle=%0d got=%b want=%b", i, tx_serial, exp_seq[i / 16]);
                end
                if (tx_serial !== exp_seq[i / 16]) bad++;
            end
            n_cmp++;
            if (bad != 0) begin n_bad++; $display("FAIL tx_a5_frame got=%0d_bad_cycles want=0", bad); end
            n_cmp++;
            if (tx_busy !== 1'b1) begin n_bad++; $display("FAIL tx_a5_busy_last_stop got=%b want=1", tx_busy); end
            @(negedge clk);
            n_cmp++;
            if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL tx_a5_busy_drop got=%b want=0", tx_busy); end
            n_cmp++;
            if (tx_serial !== 1'b1) begin n_bad++; $display("FAIL tx_a5_idle got=%b want=1", tx_serial); end
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic test_loopback();
        logic [7:0] exp_b [3];
        int         n;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h3C;
        clks_per_bit = 13'd10;
        loop_en = 1'b1;
        push(8'h00);
        push(8'hFF);
        push(8'h3C);
        for (int b = 0; b < 3; b++) begin
            n = 0;
            while (!rx_valid && n < 600) begin
                @(negedge clk);
                n++;
            end
            n_cmp++;
            if (rx_data !== exp_b[b] || !rx_valid)
                begin n_bad++; $display("FAIL loop_byte%0d got=%h(valid=%b) want=%h", b, rx_data, rx_valid, exp_b[b]); end
            pop();
        end
        n = 0;
        while (tx_busy && n < 600) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if ({frame_err, overrun_err, parity_err} !== 3'b000)
            begin n_bad++; $display("FAIL loop_errs got=%b want=000", {frame_err, overrun_err, parity_err}); end
        n_cmp++;
        if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL loop_empty got=%b want=0", rx_valid); end
        loop_en = 1'b0;
    endtask

    task automatic test_overrun();
        logic [7:0] bytes_in [5];
        bytes_in[0] = 8'h11; bytes_in[1] = 8'h22; bytes_in[2] = 8'h33;
        bytes_in[3] = 8'h44; bytes_in[4] = 8'h55;
        clks_per_bit = 13'd10;
        rx_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive_frame(bytes_in[i], 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL ovr_valid got=%b want=1", rx_valid); end
        n_cmp++;
        if (overrun_err !== 1'b1) begin n_bad++; $display("FAIL ovr_flag got=%b want=1", overrun_err); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rx_data !== bytes_in[i] || rx_valid !== 1'b1)
                begin n_bad++; $display("FAIL ovr_pop%0d got=%h(valid=%b) want=%h", i, rx_data, rx_valid, bytes_in[i]); end
            pop();
        end
        @(negedge clk);
        n_cmp++;
        if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ovr_drained got=%b want=0", rx_valid); end
        n_cmp++;
        if (overrun_err !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got=%b want=1", overrun_err); end
        clear_errors();
        @(negedge clk);
        n_cmp++;
        if (overrun_err !== 1'b0) begin n_bad++; $display("FAIL ovr_clear got=%b want=0", overrun_err); end
    endtask

    task automatic test_frame_err_glitch();
        clks_per_bit = 13'd10;
        drive_frame(8'h55, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_flag got=%b want=1", frame_err); end
        n_cmp++;
        if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL ferr_no_data got=%b want=0", rx_valid); end
        clear_errors();
        @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL ferr_clear got=%b want=0", frame_err); end
        rx_drv = 1'b0;
        repeat (3) @(posedge clk);
        rx_drv = 1'b1;
        repeat (150) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL glitch_no_frame got=%b want=0", rx_valid); end
        n_cmp++;
        if ({frame_err, overrun_err, parity_err} !== 3'b000)
            begin n_bad++; $display("FAIL glitch_no_flag got=%b want=000", {frame_err, overrun_err, parity_err}); end
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity();
        logic found;
        int   n;
        clks_per_bit = 13'd10;
        parity_odd = 1'b0;
        push(8'h07);
        wait_tx_start(found);
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL par_tx_start got=no_start want=start_bit");
        end else begin
            repeat (95) @(negedge clk);
            n_cmp++;
            if (tx_serial !== 1'b1) begin n_bad++; $display("FAIL par_tx_bit got=%b want=1", tx_serial); end
        end
        n = 0;
        while (tx_busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        drive_frame(8'h07, 1'b1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (parity_err !== 1'b1) begin n_bad++; $display("FAIL par_rx_flag got=%b want=1", parity_err); end
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h07)
            begin n_bad++; $display("FAIL par_rx_data got=%h(valid=%b) want=07", rx_data, rx_valid); end
        n_cmp++;
        if (frame_err !== 1'b0) begin n_bad++; $display("FAIL par_rx_ferr got=%b want=0", frame_err); end
        pop();
        clear_errors();
        @(negedge clk);
        n_cmp++;
        if (parity_err !== 1'b0) begin n_bad++; $display("FAIL par_clear got=%b want=0", parity_err); end
    endtask
`endif

    task automatic test_reset_mid_tx();
        logic found;
        int   lows;
        clks_per_bit = 13'd10;
        push(8'h00);
        push(8'h81);
        push(8'h42);
        wait_tx_start(found);
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL rst_mid_start got=no_start want=start_bit");
        end
        repeat (35) @(negedge clk);
        n_cmp++;
        if (tx_serial !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pre got=%b want=0", tx_serial); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (tx_serial !== 1'b1) begin n_bad++; $display("FAIL rst_mid_serial got=%b want=1", tx_serial); end
        n_cmp++;
        if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL rst_mid_ready got=%b want=1", tx_ready); end
        n_cmp++;
        if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy got=%b want=0", tx_busy); end
        rst = 1'b0;
        lows = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        n_cmp++;
        if (lows != 0) begin n_bad++; $display("FAIL rst_mid_silent got=%0d_active_cycles want=0", lows); end
    endtask

    initial begin
        rst          = 1'b1;
        clks_per_bit = 13'd16;
        tx_data      = 8'h00;
        tx_valid     = 1'b0;
        rx_ready     = 1'b0;
        parity_odd   = 1'b0;
        err_clear    = 1'b0;
        loop_en      = 1'b0;
        rx_drv       = 1'b1;

        test_reset();
        test_tx_a5();
        test_loopback();
        test_overrun();
        test_frame_err_glitch();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_reset_mid_tx();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
